axi_lite_demux: RTL and testbench



---
 rtl/axi_lite_demux_pkg.sv | 14 +
 rtl/axi_addr_decode.sv | 28 ++
 rtl/axi_lite_demux.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_demux.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_demux_pkg.sv
// Shared state encodings, response codes and sizing helper for the AXI-lite demux.
package axi_lite_demux_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} wr_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_addr_decode.sv
// Base/mask address decoder, combinational; lowest matching slave index wins.
module axi_addr_decode
  import axi_lite_demux_pkg::*;
#(
  parameter int NSLV   = 2,
  parameter int ADDR_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'ha000_0000, 32'h8000_0000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hf000_0000, 32'hf800_0000},
  localparam int IDX_W = idx_width(NSLV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  // Scan from the top down so the last (lowest-index) match is the one kept.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_lite_demux.sv
// AXI-lite 1:NSLV demux: 1 cycle master request -> slave valid, 0 cycles slave R/B -> master.
// One outstanding read and one write; masters stall via ready, slaves see valid held until handshake.
module axi_lite_demux
  import axi_lite_demux_pkg::*;
#(
  parameter int NSLV   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'ha000_0000, 32'h8000_0000},
  parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hf000_0000, 32'hf800_0000}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     m_arvalid,
  output logic                     m_arready,
  input  logic [ADDR_W-1:0]        m_araddr,
  output logic                     m_rvalid,
  input  logic                     m_rready,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [1:0]               m_rresp,
  input  logic                     m_awvalid,
  output logic                     m_awready,
  input  logic [ADDR_W-1:0]        m_awaddr,
  input  logic                     m_wvalid,
  output logic                     m_wready,
  input  logic [DATA_W-1:0]        m_wdata,
  input  logic [DATA_W/8-1:0]      m_wstrb,
  output logic                     m_bvalid,
  input  logic                     m_bready,
  output logic [1:0]               m_bresp,
  output logic [NSLV-1:0]          s_arvalid,
  input  logic [NSLV-1:0]          s_arready,
  output logic [ADDR_W-1:0]        s_araddr,
  input  logic [NSLV-1:0]          s_rvalid,
  output logic [NSLV-1:0]          s_rready,
  input  logic [NSLV*DATA_W-1:0]   s_rdata,
  input  logic [NSLV*2-1:0]        s_rresp,
  output logic [NSLV-1:0]          s_awvalid,
  input  logic [NSLV-1:0]          s_awready,
  output logic [ADDR_W-1:0]        s_awaddr,
  output logic [NSLV-1:0]          s_wvalid,
  input  logic [NSLV-1:0]          s_wready,
  output logic [DATA_W-1:0]        s_wdata,
  output logic [DATA_W/8-1:0]      s_wstrb,
  input  logic [NSLV-1:0]          s_bvalid,
  output logic [NSLV-1:0]          s_bready,
  input  logic [NSLV*2-1:0]        s_bresp
);

  localparam int IDX_W = idx_width(NSLV);

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
  } wr_req_t;

  rd_state_t r_state, r_next;
  wr_state_t w_state, w_next;
  logic [ADDR_W-1:0] raddr;
  logic [IDX_W-1:0]  rsel, wsel, ar_idx, aw_idx;
  logic              ar_hit, aw_hit, ar_take, aw_take;
  logic              aw_done, w_done, aw_fire, w_fire;
  wr_req_t           wreq;

  axi_addr_decode #(.NSLV(NSLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_ar_dec (.addr(m_araddr), .hit(ar_hit), .idx(ar_idx));

  axi_addr_decode #(.NSLV(NSLV), .ADDR_W(ADDR_W), .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
    u_aw_dec (.addr(m_awaddr), .hit(aw_hit), .idx(aw_idx));

  assign s_araddr = raddr;
  assign s_awaddr = wreq.addr;
  assign s_wdata  = wreq.data;
  assign s_wstrb  = wreq.strb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_IDLE;
      raddr   <= '0;
      rsel    <= '0;
    end else begin
      r_state <= r_next;
      if (ar_take) begin
        raddr <= m_araddr;
        rsel  <= ar_idx;
      end
    end
  end

  // Ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    r_next    = r_state;
    ar_take   = 1'b0;
    m_arready = 1'b0;
    s_arvalid = '0;
    s_rready  = '0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = OKAY;
    case (r_state)
      R_IDLE: begin
        m_arready = !rst;
        ar_take   = m_arvalid && !rst;
        if (ar_take) r_next = ar_hit ? R_ADDR : R_ERR;
      end
      R_ADDR: begin
        s_arvalid[rsel] = 1'b1;
        if (s_arready[rsel]) r_next = R_DATA;
      end
      R_DATA: begin
        m_rvalid       = s_rvalid[rsel];
        m_rdata        = s_rdata[rsel*DATA_W +: DATA_W];
        m_rresp        = s_rresp[rsel*2 +: 2];
        s_rready[rsel] = m_rready;
        if (s_rvalid[rsel] && m_rready) r_next = R_IDLE;
      end
      R_ERR: begin
        m_rvalid = 1'b1;
        m_rresp  = DECERR;
        if (m_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      wreq    <= '0;
      wsel    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_take) begin
        wreq    <= '{addr: m_awaddr, data: m_wdata, strb: m_wstrb};
        wsel    <= aw_idx;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (w_state == W_FWD) begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire)  w_done  <= 1'b1;
      end
    end
  end

  // AW and W are only taken together, so the write request is always complete.
  always_comb begin
    w_next    = w_state;
    aw_take   = 1'b0;
    aw_fire   = 1'b0;
    w_fire    = 1'b0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    s_awvalid = '0;
    s_wvalid  = '0;
    s_bready  = '0;
    m_bvalid  = 1'b0;
    m_bresp   = OKAY;
    case (w_state)
      W_IDLE: begin
        aw_take   = m_awvalid && m_wvalid && !rst;
        m_awready = aw_take;
        m_wready  = aw_take;
        if (aw_take) w_next = aw_hit ? W_FWD : W_ERR;
      end
      W_FWD: begin
        s_awvalid[wsel] = !aw_done;
        s_wvalid[wsel]  = !w_done;
        aw_fire = !aw_done && s_awready[wsel];
        w_fire  = !w_done && s_wready[wsel];
        if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_RESP;
      end
      W_RESP: begin
        m_bvalid       = s_bvalid[wsel];
        m_bresp        = s_bresp[wsel*2 +: 2];
        s_bready[wsel] = m_bready;
        if (s_bvalid[wsel] && m_bready) w_next = W_IDLE;
      end
      W_ERR: begin
        m_bvalid = 1'b1;
        m_bresp  = DECERR;
        if (m_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_demux.sv
// Directed bench for axi_lite_demux: read/write vector tables plus multi-cycle corner sequences.
module tb_axi_lite_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;
  logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp, s_bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_demux dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  typedef struct {
    logic [31:0] addr;
    int          ar_dly;
    int          r_dly;
    logic [31:0] rdata0, rdata1;
    logic [1:0]  rresp0, rresp1;
    logic [1:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } rd_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [1:0]  bresp0, bresp1;
    logic [1:0]  exp_sel;
    logic [1:0]  exp_bresp;
  } wr_vec_t;

  rd_vec_t rd_tab[7];
  wr_vec_t wr_tab[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_read(input rd_vec_t v);
    int sel;
    sel = (v.exp_sel == 2'b10) ? 1 : 0;
    @(negedge clk);
    m_arvalid = 1'b1; m_araddr = v.addr; m_rready = 1'b1;
    s_rdata = {v.rdata1, v.rdata0}; s_rresp = {v.rresp1, v.rresp0};
    #1 chk("rd_arready", m_arready, 1);
    @(negedge clk);
    m_arvalid = 1'b0; m_araddr = '0;
    #1 chk("rd_s_arvalid", s_arvalid, v.exp_sel);
    if (v.exp_sel != 2'b00) begin
      chk("rd_s_araddr", s_araddr, v.addr);
      repeat (v.ar_dly) @(negedge clk);
      #1 chk("rd_arvalid_hold", s_arvalid, v.exp_sel);
      s_arready[sel] = 1'b1;
      @(negedge clk);
      s_arready = '0;
      #1 chk("rd_arvalid_drop", s_arvalid, 0);
      chk("rd_rvalid_early", m_rvalid, 0);
      repeat (v.r_dly) @(negedge clk);
      s_rvalid[sel] = 1'b1;
      #1 chk("rd_s_rready", s_rready, v.exp_sel);
    end
    chk("rd_m_rvalid", m_rvalid, 1);
    chk("rd_m_rdata", m_rdata, v.exp_rdata);
    chk("rd_m_rresp", m_rresp, v.exp_rresp);
    @(negedge clk);
    s_rvalid = '0; m_rready = 1'b0;
    #1 chk("rd_done_rvalid", m_rvalid, 0);
    chk("rd_done_arready", m_arready, 1);
  endtask

  task automatic run_write(input wr_vec_t v);
    int sel;
    int aw_cnt;
    int w_cnt;
    int last;
    sel = (v.exp_sel == 2'b10) ? 1 : 0;
    aw_cnt = 0; w_cnt = 0;
    last = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    @(negedge clk);
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = v.addr; m_wdata = v.data; m_wstrb = v.strb;
    m_bready = 1'b1; s_bresp = {v.bresp1, v.bresp0};
    #1 chk("wr_awready", m_awready, 1);
    chk("wr_wready", m_wready, 1);
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
    #1 chk("wr_s_awvalid", s_awvalid, v.exp_sel);
    chk("wr_s_wvalid", s_wvalid, v.exp_sel);
    if (v.exp_sel != 2'b00) begin
      chk("wr_s_awaddr", s_awaddr, v.addr);
      chk("wr_s_wdata", s_wdata, v.data);
      chk("wr_s_wstrb", s_wstrb, v.strb);
      for (int k = 0; k <= last; k++) begin
        s_awready[sel] = (k >= v.aw_dly);
        s_wready[sel]  = (k >= v.w_dly);
        #1;
        if (s_awvalid[sel] && s_awready[sel]) aw_cnt++;
        if (s_wvalid[sel] && s_wready[sel]) w_cnt++;
        @(negedge clk);
      end
      s_awready = '0; s_wready = '0;
      #1 chk("wr_aw_count", aw_cnt, 1);
      chk("wr_w_count", w_cnt, 1);
      chk("wr_valids_drop", {s_awvalid, s_wvalid}, 0);
      chk("wr_bvalid_early", m_bvalid, 0);
      repeat (v.b_dly) @(negedge clk);
      s_bvalid[sel] = 1'b1;
      #1 chk("wr_s_bready", s_bready, v.exp_sel);
    end
    chk("wr_m_bvalid", m_bvalid, 1);
    chk("wr_m_bresp", m_bresp, v.exp_bresp);
    @(negedge clk);
    s_bvalid = '0; m_bready = 1'b0;
    #1 chk("wr_done_bvalid", m_bvalid, 0);
  endtask

  initial begin
    //            addr          ar r  rdata0        rdata1        rr0    rr1    sel    exp_rdata     exp_rresp
    rd_tab[0] = '{32'h8000_0010, 1, 3, 32'hdead_beef, 32'h1111_1111, 2'b00, 2'b10, 2'b01, 32'hdead_beef, 2'b00};
    rd_tab[1] = '{32'ha000_0004, 0, 0, 32'h2222_2222, 32'hcafe_f00d, 2'b00, 2'b01, 2'b10, 32'hcafe_f00d, 2'b01};
    rd_tab[2] = '{32'h0000_0000, 0, 0, 32'h3333_3333, 32'h4444_4444, 2'b00, 2'b00, 2'b00, 32'h0000_0000, 2'b11};
    rd_tab[3] = '{32'h87ff_fffc, 2, 1, 32'h0bad_cafe, 32'h5555_5555, 2'b10, 2'b00, 2'b01, 32'h0bad_cafe, 2'b10};
    rd_tab[4] = '{32'h8800_0000, 0, 0, 32'h6666_6666, 32'h7777_7777, 2'b00, 2'b00, 2'b00, 32'h0000_0000, 2'b11};
    rd_tab[5] = '{32'hafff_fff0, 1, 2, 32'h8888_8888, 32'h1357_9bdf, 2'b11, 2'b00, 2'b10, 32'h1357_9bdf, 2'b00};
    rd_tab[6] = '{32'hb000_0000, 0, 0, 32'h9999_9999, 32'haaaa_aaaa, 2'b00, 2'b00, 2'b00, 32'h0000_0000, 2'b11};
    //            addr           data           strb     aw w  b  br0    br1    sel    exp_bresp
    wr_tab[0] = '{32'ha000_0004, 32'h1234_5678, 4'b0011, 2, 0, 1, 2'b01, 2'b00, 2'b10, 2'b00};
    wr_tab[1] = '{32'h8000_0100, 32'h89ab_cdef, 4'b1111, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00};
    wr_tab[2] = '{32'h8400_0008, 32'h0f0f_0f0f, 4'b1000, 0, 3, 2, 2'b10, 2'b00, 2'b01, 2'b10};
    wr_tab[3] = '{32'h0000_0000, 32'hffff_ffff, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11};
    wr_tab[4] = '{32'ha800_0000, 32'h0000_00a5, 4'b0001, 1, 1, 0, 2'b00, 2'b01, 2'b10, 2'b01};

    rst = 1'b1;
    m_arvalid = 1'b1; m_araddr = 32'h8000_0000; m_rready = 1'b1;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'ha000_0000; m_wdata = '0; m_wstrb = '0; m_bready = 1'b1;
    s_arready = '0; s_rvalid = '0; s_rdata = '0; s_rresp = '0;
    s_awready = '0; s_wready = '0; s_bvalid = '0; s_bresp = '0;
    repeat (2) @(negedge clk);
    #1 chk("rst_ready", {m_arready, m_awready, m_wready}, 0);
    chk("rst_valid", {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid}, 0);
    chk("rst_regs", {s_araddr, s_awaddr}, 0);
    @(negedge clk);
    rst = 1'b0; m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0; m_rready = 1'b0; m_bready = 1'b0;

    foreach (rd_tab[i]) run_read(rd_tab[i]);
    foreach (wr_tab[i]) run_write(wr_tab[i]);

    // AW without W must not be accepted.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m_awvalid = 1'b1; m_wvalid = 1'b0; m_awaddr = 32'h8000_0000;
      #1 chk("aw_only_ready", {m_awready, m_wready}, 0);
      chk("aw_only_slv", {s_awvalid, s_wvalid}, 0);
    end
    run_write(wr_tab[1]);

    // Concurrent read of slave 0 and write to slave 1, master stalls R/B.
    @(negedge clk);
    m_arvalid = 1'b1; m_araddr = 32'h8000_0020; m_rready = 1'b0;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_awaddr = 32'ha000_0008; m_wdata = 32'h0102_0304; m_wstrb = 4'hf;
    m_bready = 1'b0;
    s_rdata = {32'h0, 32'h5555_aaaa}; s_rresp = 4'b0000; s_bresp = 4'b0100;
    #1 chk("cc_ready", {m_arready, m_awready, m_wready}, 3'b111);
    @(negedge clk);
    m_arvalid = 1'b0; m_awvalid = 1'b0; m_wvalid = 1'b0;
    s_arready = 2'b01; s_awready = 2'b10; s_wready = 2'b10;
    #1 chk("cc_s_arvalid", s_arvalid, 2'b01);
    chk("cc_s_awvalid", {s_awvalid, s_wvalid}, 4'b1010);
    @(negedge clk);
    s_arready = '0; s_awready = '0; s_wready = '0;
    s_rvalid = 2'b01; s_bvalid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1 chk("cc_r_stall", {m_rvalid, m_rdata, m_rresp}, {1'b1, 32'h5555_aaaa, 2'b00});
      chk("cc_b_stall", {m_bvalid, m_bresp}, 3'b101);
      chk("cc_slv_ready", {s_rready, s_bready}, 0);
      @(negedge clk);
    end
    m_rready = 1'b1; m_bready = 1'b1;
    #1 chk("cc_slv_ready_go", {s_rready, s_bready}, 4'b0110);
    @(negedge clk);
    s_rvalid = '0; s_bvalid = '0; m_rready = 1'b0; m_bready = 1'b0;
    #1 chk("cc_done", {m_rvalid, m_bvalid}, 0);
    chk("cc_idle", m_arready, 1);

    // Reset in the middle of a read data phase.
    @(negedge clk);
    m_arvalid = 1'b1; m_araddr = 32'ha000_0000;
    @(negedge clk);
    m_arvalid = 1'b0; s_arready = 2'b10;
    @(negedge clk);
    s_arready = '0; s_rvalid = 2'b10; s_rdata = {32'h7777_0000, 32'h0};
    #1 chk("rr_pre_rvalid", m_rvalid, 1);
    rst = 1'b1; m_rready = 1'b1;
    #1 chk("rr_rvalid", m_rvalid, 0);
    chk("rr_s_rready", s_rready, 0);
    chk("rr_arready", m_arready, 0);
    @(negedge clk);
    rst = 1'b0; s_rvalid = '0; m_rready = 1'b0;
    #1 chk("rr_no_resp", m_rvalid, 0);
    run_read(rd_tab[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
